// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared calendar constants, FSM state type and month-length helper
//
// Shared by the month counter (months) and the day counter.
//   JAN..DEC, MONTH_MAX : month encodings (1..12) and the wrap point
//   month_state_t       : month counter FSM states
//   days_in_month()     : 28/29/30/31 from month and the two year LSBs
package clock_pkg;

    localparam logic [5:0] JAN       = 6'd1;
    localparam logic [5:0] FEB       = 6'd2;
    localparam logic [5:0] MAR       = 6'd3;
    localparam logic [5:0] APR       = 6'd4;
    localparam logic [5:0] MAY       = 6'd5;
    localparam logic [5:0] JUN       = 6'd6;
    localparam logic [5:0] JUL       = 6'd7;
    localparam logic [5:0] AUG       = 6'd8;
    localparam logic [5:0] SEP       = 6'd9;
    localparam logic [5:0] OCT       = 6'd10;
    localparam logic [5:0] NOV       = 6'd11;
    localparam logic [5:0] DEC       = 6'd12;
    localparam logic [5:0] MONTH_MAX = DEC;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_SET   = 2'd1,
        S_CLAMP = 2'd2
    } month_state_t;

    // Years 00..99 of one century: every year with LSBs 00 is a leap year.
    // Illegal month codes fall into the 31-day default.
    function automatic logic [5:0] days_in_month(input logic [5:0] month,
                                                 input logic [1:0] year_lsb2);
        logic [5:0] days;
        case (month)
            FEB:                days = (year_lsb2 == 2'b00) ? 6'd29 : 6'd28;
            APR, JUN, SEP, NOV: days = 6'd30;
            default:            days = 6'd31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/month_len_lut.sv
// rtl/month_len_lut.sv - combinational month/year to days-in-month lookup
//
// Ports:
//   month_i     [5:0] month, 1..12
//   year_lsb2_i [1:0] two LSBs of the year (00 = leap year)
//   days_o      [5:0] 28, 29, 30 or 31
module month_len_lut
    import clock_pkg::*;
(
    input  logic [5:0] month_i,
    input  logic [1:0] year_lsb2_i,
    output logic [5:0] days_o
);

    always_comb begin
        days_o = days_in_month(month_i, year_lsb2_i);
    end

endmodule

// File: rtl/months.sv
// rtl/months.sv - month counter for the century clock (run advance, setup stepping, day clamp)
//
// Optional build macro MONTHS_BCD_OUT_EN adds the registered BCD output month_bcd.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   display         0 = run mode, 1 = setup/display mode
//   setup_month     active-low month-field select while in setup
//   done_day        day rollover strobe from the day counter
//   inc_dec_month   setup step direction, 1 = up, 0 = down
//   tick            debounced button strobe
//   curr_day        current day 1..31
//   curr_year       current year 0..99
//   month           current month 1..12
//   done_month      one-cycle year-advance strobe
//   day_clamp_req   one-cycle request for the day counter to load day_clamp_val
//   day_clamp_val   days in the current month
//   month_bcd       (MONTHS_BCD_OUT_EN only) two-digit BCD month
module months
    import clock_pkg::*;
#(
    parameter int MONTH_RST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       display,
    input  logic       setup_month,
    input  logic       done_day,
    input  logic       inc_dec_month,
    input  logic       tick,
    input  logic [5:0] curr_day,
    input  logic [6:0] curr_year,
    output logic [5:0] month,
    output logic       done_month,
    output logic       day_clamp_req,
`ifdef MONTHS_BCD_OUT_EN
    output logic [7:0] month_bcd,
`endif
    output logic [5:0] day_clamp_val
);

    localparam logic [5:0] RST_MONTH = 6'(MONTH_RST);

    month_state_t state_q, state_d;
    logic [5:0]   month_q, month_d;
    logic         done_month_q, done_month_d;
    logic         clamp_req_q, clamp_req_d;
    logic [5:0]   clamp_val_q, clamp_val_d;
    logic [5:0]   month_days;
    logic         month_illegal;
    logic         set_step;

    // Only the leap-year LSBs matter for month length.
    logic unused_year_bits;
    assign unused_year_bits = &{1'b0, curr_year[6:2]};

    month_len_lut u_month_len_lut (
        .month_i     (month_q),
        .year_lsb2_i (curr_year[1:0]),
        .days_o      (month_days)
    );

    assign month_illegal = (month_q == 6'd0) || (month_q > MONTH_MAX);
    assign set_step      = !setup_month && tick;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Leaving setup goes through S_CLAMP so a day made
    // illegal by a year change in setup gets corrected.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   state_d = display ? S_SET : S_RUN;
            S_SET:   state_d = (!display || set_step) ? S_CLAMP : S_SET;
            S_CLAMP: state_d = display ? S_SET : S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Datapath / output next-state logic
    always_comb begin
        month_d      = month_q;
        done_month_d = 1'b0;
        clamp_req_d  = 1'b0;
        clamp_val_d  = month_days;
        if (month_illegal) begin
            // Corrupted month recovers silently, no year strobe.
            month_d = JAN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (done_day) begin
                        if (month_q == MONTH_MAX) begin
                            month_d      = JAN;
                            done_month_d = 1'b1;
                        end else begin
                            month_d = month_q + 6'd1;
                        end
                    end
                end
                S_SET: begin
                    if (set_step) begin
                        if (inc_dec_month) begin
                            month_d = (month_q == MONTH_MAX) ? JAN : month_q + 6'd1;
                        end else begin
                            month_d = (month_q == JAN) ? MONTH_MAX : month_q - 6'd1;
                        end
                    end
                end
                S_CLAMP: begin
                    // month_q already holds the new month here.
                    clamp_req_d = (curr_day > month_days);
                end
                default: begin
                    month_d = month_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            month_q      <= RST_MONTH;
            done_month_q <= 1'b0;
            clamp_req_q  <= 1'b0;
            clamp_val_q  <= 6'd31;
        end else begin
            month_q      <= month_d;
            done_month_q <= done_month_d;
            clamp_req_q  <= clamp_req_d;
            clamp_val_q  <= clamp_val_d;
        end
    end

    assign month         = month_q;
    assign done_month    = done_month_q;
    assign day_clamp_req = clamp_req_q;
    assign day_clamp_val = clamp_val_q;

`ifdef MONTHS_BCD_OUT_EN
    function automatic logic [7:0] to_bcd(input logic [5:0] m);
        logic [5:0] ones;
        logic [7:0] bcd;
        if (m >= 6'd10) begin
            ones = m - 6'd10;
            bcd  = {4'h1, ones[3:0]};
        end else begin
            bcd  = {4'h0, m[3:0]};
        end
        return bcd;
    endfunction

    logic [7:0] month_bcd_q;

    // Loaded from month_d so it changes on the same edge as month.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            month_bcd_q <= to_bcd(RST_MONTH);
        end else begin
            month_bcd_q <= to_bcd(month_d);
        end
    end

    assign month_bcd = month_bcd_q;
`endif

endmodule

// File: tb/tb_months.sv
// tb/tb_months.sv - directed self-checking bench for the month counter
module tb_months;

    logic       clk;
    logic       rst;
    logic       display;
    logic       setup_month;
    logic       done_day;
    logic       inc_dec_month;
    logic       tick;
    logic [5:0] curr_day;
    logic [6:0] curr_year;
    logic [5:0] month;
    logic       done_month;
    logic       day_clamp_req;
    logic [5:0] day_clamp_val;
`ifdef MONTHS_BCD_OUT_EN
    logic [7:0] month_bcd;
`endif

    int tests_run;
    int tests_failed;

    months #(.MONTH_RST(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .display       (display),
        .setup_month   (setup_month),
        .done_day      (done_day),
        .inc_dec_month (inc_dec_month),
        .tick          (tick),
        .curr_day      (curr_day),
        .curr_year     (curr_year),
        .month         (month),
        .done_month    (done_month),
        .day_clamp_req (day_clamp_req),
`ifdef MONTHS_BCD_OUT_EN
        .month_bcd     (month_bcd),
`endif
        .day_clamp_val (day_clamp_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick pulse driven on a falling edge; returns one falling edge later,
    // i.e. just after the rising edge that sampled it.
    task automatic tick_pulse(input logic inc);
        @(negedge clk);
        tick          = 1'b1;
        inc_dec_month = inc;
        @(negedge clk);
        tick          = 1'b0;
    endtask

    task automatic day_pulse();
        @(negedge clk);
        done_day = 1'b1;
        @(negedge clk);
        done_day = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (month !== 6'd1) begin
            tests_failed++;
            $display("FAIL reset_month: got %0d expected 1", month);
        end
        tests_run++;
        if (done_month !== 1'b0 || day_clamp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: got done_month=%b day_clamp_req=%b expected 0/0",
                     done_month, day_clamp_req);
        end
        tests_run++;
        if (day_clamp_val !== 6'd31) begin
            tests_failed++;
            $display("FAIL reset_clamp_val: got %0d expected 31", day_clamp_val);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_run_advance();
        logic [5:0] exp_m;
        for (int i = 1; i <= 12; i++) begin
            day_pulse();
            exp_m = (i == 12) ? 6'd1 : 6'(i + 1);
            tests_run++;
            if (month !== exp_m) begin
                tests_failed++;
                $display("FAIL run_month_%0d: got %0d expected %0d", i, month, exp_m);
            end
            tests_run++;
            if (done_month !== (i == 12)) begin
                tests_failed++;
                $display("FAIL run_done_month_%0d: got %b expected %b", i, done_month, (i == 12));
            end
        end
        @(negedge clk);
        tests_run++;
        if (done_month !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_done_month_width: got %b expected 0", done_month);
        end
    endtask

    task automatic test_setup_dec_wrap();
        @(negedge clk);
        display     = 1'b1;
        setup_month = 1'b0;
        curr_day    = 6'd15;
        tick_pulse(1'b0);
        tests_run++;
        if (month !== 6'd12 || done_month !== 1'b0) begin
            tests_failed++;
            $display("FAIL setup_dec_wrap: got month=%0d done_month=%b expected 12/0", month, done_month);
        end
        @(negedge clk);
        tests_run++;
        if (day_clamp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL setup_dec_no_clamp: got %b expected 0", day_clamp_req);
        end
    endtask

    task automatic test_clamp();
        curr_day  = 6'd31;
        curr_year = 7'd5;
        tick_pulse(1'b1);
        tests_run++;
        if (month !== 6'd1) begin
            tests_failed++;
            $display("FAIL setup_inc_wrap: got %0d expected 1", month);
        end
        @(negedge clk);
        tick_pulse(1'b1);
        tests_run++;
        if (month !== 6'd2 || day_clamp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL clamp_feb_1clk: got month=%0d req=%b expected 2/0", month, day_clamp_req);
        end
        @(negedge clk);
        tests_run++;
        if (day_clamp_req !== 1'b1 || day_clamp_val !== 6'd28) begin
            tests_failed++;
            $display("FAIL clamp_feb_28: got req=%b val=%0d expected 1/28", day_clamp_req, day_clamp_val);
        end
        @(negedge clk);
        tests_run++;
        if (day_clamp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL clamp_one_cycle: got %b expected 0", day_clamp_req);
        end
        curr_year = 7'd4;
        tick_pulse(1'b0);
        @(negedge clk);
        tick_pulse(1'b1);
        @(negedge clk);
        tests_run++;
        if (day_clamp_req !== 1'b1 || day_clamp_val !== 6'd29) begin
            tests_failed++;
            $display("FAIL clamp_feb_29: got req=%b val=%0d expected 1/29", day_clamp_req, day_clamp_val);
        end
        // Leaving setup with day 30 in a 28-day February
        curr_year = 7'd5;
        curr_day  = 6'd30;
        @(negedge clk);
        display = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (day_clamp_req !== 1'b1 || day_clamp_val !== 6'd28) begin
            tests_failed++;
            $display("FAIL exit_setup_clamp: got req=%b val=%0d expected 1/28", day_clamp_req, day_clamp_val);
        end
        day_pulse();
        tests_run++;
        if (month !== 6'd3) begin
            tests_failed++;
            $display("FAIL back_to_run: got %0d expected 3", month);
        end
    endtask

    task automatic test_ignore();
        @(negedge clk);
        display     = 1'b1;
        setup_month = 1'b1;
        @(negedge clk);
        tick_pulse(1'b1);
        day_pulse();
        @(negedge clk);
        tests_run++;
        if (month !== 6'd3 || done_month !== 1'b0 || day_clamp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL setup_ignore: got month=%0d done=%b req=%b expected 3/0/0",
                     month, done_month, day_clamp_req);
        end
        // tick and done_day together in setup: tick wins
        setup_month   = 1'b0;
        @(negedge clk);
        tick          = 1'b1;
        done_day      = 1'b1;
        inc_dec_month = 1'b1;
        @(negedge clk);
        tick          = 1'b0;
        done_day      = 1'b0;
        tests_run++;
        if (month !== 6'd4 || done_month !== 1'b0) begin
            tests_failed++;
            $display("FAIL tick_and_day: got month=%0d done=%b expected 4/0", month, done_month);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_clamp();
        curr_day = 6'd31;
        tick_pulse(1'b1);
        @(negedge clk);
        tick_pulse(1'b1);
        tests_run++;
        if (month !== 6'd6) begin
            tests_failed++;
            $display("FAIL pre_reset_month: got %0d expected 6", month);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (month !== 6'd1 || day_clamp_req !== 1'b0 || day_clamp_val !== 6'd31) begin
            tests_failed++;
            $display("FAIL reset_mid_clamp: got month=%0d req=%b val=%0d expected 1/0/31",
                     month, day_clamp_req, day_clamp_val);
        end
        @(negedge clk);
        tests_run++;
        if (day_clamp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_clamp_abort: got %b expected 0", day_clamp_req);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef MONTHS_BCD_OUT_EN
    task automatic test_bcd();
        tests_run++;
        if (month_bcd !== 8'h01) begin
            tests_failed++;
            $display("FAIL bcd_reset: got %h expected 01", month_bcd);
        end
        curr_day = 6'd1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            tick_pulse(1'b1);
            @(negedge clk);
        end
        tests_run++;
        if (month !== 6'd10 || month_bcd !== 8'h10) begin
            tests_failed++;
            $display("FAIL bcd_10: got month=%0d bcd=%h expected 10/10", month, month_bcd);
        end
        tick_pulse(1'b1);
        @(negedge clk);
        tick_pulse(1'b1);
        tests_run++;
        if (month !== 6'd12 || month_bcd !== 8'h12) begin
            tests_failed++;
            $display("FAIL bcd_12: got month=%0d bcd=%h expected 12/12", month, month_bcd);
        end
    endtask
`endif

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        display       = 1'b0;
        setup_month   = 1'b1;
        done_day      = 1'b0;
        inc_dec_month = 1'b1;
        tick          = 1'b0;
        curr_day      = 6'd1;
        curr_year     = 7'd0;

        test_reset();
        test_run_advance();
        test_setup_dec_wrap();
        test_clamp();
        test_ignore();
        test_reset_mid_clamp();
`ifdef MONTHS_BCD_OUT_EN
        test_bcd();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
